// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU issue stage: decode, operand register, 4-deep in-order response FIFO
module alu_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_aluop,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7b5,
    input  logic        req_op5,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal
);

    logic [3:0]  dec_ctl;
    logic        dec_ill;
    logic        issue_vld;
    logic        issue_ill;
    logic [31:0] fifo_result [4];
    logic        fifo_zero   [4];
    logic        fifo_ill    [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_count;
    logic [2:0]  occupancy;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        dec_ctl = 4'b0010;
        dec_ill = 1'b0;
        case (req_aluop)
            2'b00: dec_ctl = 4'b0010;
            2'b01: dec_ctl = 4'b0110;
            2'b10: begin
                case (req_funct3)
                    3'b000:  dec_ctl = (req_op5 & req_funct7b5) ? 4'b0110 : 4'b0010;
                    3'b010:  dec_ctl = 4'b0111;
                    3'b110:  dec_ctl = 4'b0001;
                    3'b111:  dec_ctl = 4'b0000;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // The in-flight issue slot counts as occupied so a push can never find the FIFO full.
    assign occupancy = fifo_count + {2'b00, issue_vld};
    assign req_ready = (occupancy < 3'd4);
    assign accept    = req_valid & req_ready;
    assign push      = issue_vld;
    assign rsp_valid = (fifo_count != 3'd0);
    assign pop       = rsp_valid & rsp_ready;

    assign rsp_result  = fifo_result[rd_ptr];
    assign rsp_zero    = fifo_zero[rd_ptr];
    assign rsp_illegal = fifo_ill[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_vld   <= 1'b0;
            issue_ill   <= 1'b0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_control <= 4'b0000;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            fifo_count  <= 3'd0;
        end else begin
            issue_vld <= accept;
            if (accept) begin
                alu_a       <= req_a;
                alu_b       <= req_b;
                alu_control <= dec_ctl;
                issue_ill   <= dec_ill;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
        end
    end

    // Payload storage needs no reset; validity is carried entirely by fifo_count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_result[wr_ptr] <= issue_ill ? 32'd0 : alu_result;
            fifo_zero[wr_ptr]   <= issue_ill ? 1'b0 : alu_zero;
            fifo_ill[wr_ptr]    <= issue_ill;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with a reference ALU and randomized traffic
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_aluop;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic        req_op5;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_illegal;

    alu_issue dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_op5(req_op5), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // Combinational ALU attached to the issue ports.
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0001: alu_result = alu_a | alu_b;
            4'b0000: alu_result = alu_a & alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rsp_count = 0;
    int   first_pop = -1;
    int   last_pop = -1;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: operation chosen by name, then evaluated with plain arithmetic.
    typedef enum int {OP_ADD, OP_SUB, OP_SLT, OP_OR, OP_AND, OP_ILL} op_e;

    function automatic op_e ref_op(input logic [1:0] aluop, input logic [2:0] f3,
                                   input logic f7, input logic op5);
        if (aluop == 2'b00) return OP_ADD;
        if (aluop == 2'b01) return OP_SUB;
        if (aluop == 2'b11) return OP_ILL;
        if (f3 == 3'b000) return (op5 && f7) ? OP_SUB : OP_ADD;
        if (f3 == 3'b010) return OP_SLT;
        if (f3 == 3'b110) return OP_OR;
        if (f3 == 3'b111) return OP_AND;
        return OP_ILL;
    endfunction

    function automatic logic [3:0] ref_ctl(input op_e op);
        case (op)
            OP_SUB:  return 4'b0110;
            OP_SLT:  return 4'b0111;
            OP_OR:   return 4'b0001;
            OP_AND:  return 4'b0000;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic rsp_t ref_rsp(input op_e op, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD:  r.res = a + b;
            OP_SUB:  r.res = a - b;
            OP_SLT:  r.res = (sa < sb) ? 32'd1 : 32'd0;
            OP_OR:   r.res = a | b;
            OP_AND:  r.res = a & b;
            default: r.res = 32'd0;
        endcase
        r.ill = (op == OP_ILL);
        r.z   = !r.ill && (r.res == 32'd0);
        return r;
    endfunction

    // Acceptance monitor: pushes expected responses and checks the issue registers one cycle on.
    initial begin
        logic        pend;
        logic [3:0]  pend_ctl;
        logic [31:0] pend_a, pend_b;
        op_e         op;
        pend = 1'b0;
        pend_ctl = 4'd0;
        pend_a = 32'd0;
        pend_b = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("alu_control", {28'd0, alu_control}, {28'd0, pend_ctl});
                    check("alu_operands", alu_a ^ {alu_b[15:0], alu_b[31:16]},
                          pend_a ^ {pend_b[15:0], pend_b[31:16]});
                end
                pend = 1'b0;
                if (req_valid && req_ready) begin
                    op = ref_op(req_aluop, req_funct3, req_funct7b5, req_op5);
                    exp_q.push_back(ref_rsp(op, req_a, req_b));
                    pend = 1'b1;
                    pend_ctl = ref_ctl(op);
                    pend_a = req_a;
                    pend_b = req_b;
                end
            end
        end
    end

    // Response monitor: every handshake pops and compares the scoreboard head.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && rsp_ready) begin
                rsp_count++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                if (exp_q.size() == 0) begin
                    check("stale_response", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_payload", {rsp_result ^ {31'd0, rsp_zero}, 31'd0, rsp_illegal},
                          {e.res ^ {31'd0, e.z}, 31'd0, e.ill});
                end
            end
        end
    end

    task automatic set_fields(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                              input logic o5, input logic [31:0] a, input logic [31:0] b);
        req_aluop = op;
        req_funct3 = f3;
        req_funct7b5 = f7;
        req_op5 = o5;
        req_a = a;
        req_b = b;
    endtask

    task automatic set_rand;
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        set_fields(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), a, b);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic o5, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        set_fields(op, f3, f7, o5, a, b);
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n, input logic rr);
        req_valid = 1'b0;
        rsp_ready = rr;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int acc;
        int drops;
        reset = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        set_fields(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_alu_control", {28'd0, alu_control}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_alu_b", alu_b, 32'd0);
        reset = 1'b0;

        // R-type sub of equal operands, plus accept-to-response latency.
        send(2'b10, 3'b000, 1'b1, 1'b1, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        check("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        idle(3, 1'b1);

        send(2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
        send(2'b11, 3'b000, 1'b0, 1'b1, 32'd7, 32'd9);
        send(2'b00, 3'b101, 1'b1, 1'b1, 32'd7, 32'd9);
        send(2'b10, 3'b011, 1'b0, 1'b1, 32'd1, 32'd2);
        send(2'b10, 3'b000, 1'b1, 1'b0, 32'd3, 32'd4);
        idle(4, 1'b1);

        // Backpressure: only four requests fit with responses stalled.
        acc = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_rand();
            req_valid = 1'b1;
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("full_accept_count", acc, 32'd4);
        check("full_req_ready", {31'd0, req_ready}, 32'd0);
        rsp_count = 0;
        idle(8, 1'b1);
        check("drain_count", rsp_count, 32'd4);
        check("resume_req_ready", {31'd0, req_ready}, 32'd1);
        send(2'b01, 3'b000, 1'b0, 1'b0, 32'd10, 32'd3);
        idle(3, 1'b1);

        // Streaming: one request and one response per cycle.
        rsp_count = 0;
        first_pop = -1;
        last_pop = -1;
        drops = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_rand();
            req_valid = 1'b1;
            @(negedge clk);
            if (!req_ready) drops++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        idle(4, 1'b1);
        check("stream_ready_drops", drops, 32'd0);
        check("stream_rsp_count", rsp_count, 32'd16);
        check("stream_rsp_span", last_pop - first_pop, 32'd15);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            set_rand();
            req_valid = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        idle(10, 1'b1);
        check("random_drained", exp_q.size(), 32'd0);

        // Reset with two queued and one in flight, racing a request and a pop.
        rsp_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        send(2'b00, 3'b000, 1'b0, 1'b0, 32'd2, 32'd2);
        send(2'b00, 3'b000, 1'b0, 1'b0, 32'd3, 32'd3);
        reset = 1'b1;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        rsp_count = 0;
        check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midreset_req_ready", {31'd0, req_ready}, 32'd1);
        check("midreset_alu_control", {28'd0, alu_control}, 32'd0);
        idle(6, 1'b1);
        check("midreset_no_stale", rsp_count, 32'd0);
        send(2'b10, 3'b110, 1'b0, 1'b1, 32'h0F0F_0000, 32'h0000_00F0);
        idle(4, 1'b1);
        check("final_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
